load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit of the pipelined core: the consumer of the execute stage's ALU result (effective address) and forwarded rs2 (store data). It turns one load or store per instruction into a single request/acknowledge transaction on the data-memory port. It drives byte enables and lane-replicated store data, and sign/zero-extends load data for writeback. It stalls the pipeline while a transaction is outstanding.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- i_clk  in  1  core clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  a valid instruction occupies the memory stage.
- i_memRead  in  1  instruction is a load.
- i_memWrite  in  1  instruction is a store; wins if both read and write are high.
- i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  XLEN  effective byte address from execute.
- i_storeData  in  XLEN  forwarded rs2 value.
- o_stall  out  1  freeze all upstream pipeline registers this cycle.
- o_loadData  out  XLEN  extended load result; registered.
- o_loadValid  out  1  one-cycle pulse, o_loadData is new.
- o_memFault  out  1  misaligned address or illegal funct3; combinational.
- o_dmemReq  out  1  bus request.
- o_dmemWe  out  1  1 = write.
- o_dmemAddr  out  XLEN  word address; bits [1:0] are always 0.
- o_dmemWdata  out  XLEN  store data, replicated across lanes.
- o_dmemBe  out  4  byte enables.
- i_dmemAck  in  1  completes the current request.
- i_dmemRdata  in  XLEN  read word; valid in the ack cycle.

## Operation
- **States.**
  - IDLE: no request outstanding.
  - BUSY: request outstanding.
- **Operation definition.** newOp = i_valid & (i_memRead | i_memWrite) & ~o_memFault.
- **IDLE.**
  - newOp: latch addr, we, funct3 and formatted wdata/be, then move to BUSY.
  - o_stall = newOp.
  - Not newOp: stay in IDLE.
- **BUSY.**
  - o_dmemReq = 1; address, data, enables and we come from the latched values and are held stable until ack.
  - o_stall = ~i_dmemAck.
  - On ack, go to IDLE. For a load, also register the extended data into o_loadData and pulse o_loadValid in the next cycle.
- **Fault conditions.** o_memFault is asserted when all of the following hold:
  - i_valid and (read or write);
  - state is IDLE;
  - and one of: funct3 ∈ {011, 110, 111}; H/HU with addr[0]=1; W with addr[1:0]≠0.
  - Store funct3 ∈ {100, 101} is also illegal.
  - A fault causes no bus transaction and no stall.
- **Store formatting.**
  - SB: wdata = {4{rs2[7:0]}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = rs2, be = 1111.
- **Load formatting.**
  - The byte or half is selected by the latched addr[1:0].
  - B/H are sign-extended; BU/HU are zero-extended; W passes through.
  - Loads drive be = 1111.
- **Ignored inputs.** i_dmemAck in IDLE is ignored. o_dmemRdata is ignored for stores.

## Timing
- **Reset values.** All outputs are 0 and state is IDLE. Reset is asynchronous: o_dmemReq drops immediately, even mid-transaction, and the outstanding access is abandoned.
- **Minimum latency.** Op presented in cycle N, request in N+1, ack in N+1 → o_loadValid/o_loadData in N+2.
- **Stall window.** o_stall is high in cycles N..(ack cycle − 1) and low in the ack cycle, so the pipeline advances on the ack edge.
- **Back-to-back.** A new op can be presented in the cycle after ack; the minimum cost is 2 cycles per access.
- **Request hold.** o_dmemReq stays high continuously from request to ack, with no bubbles; the bus may hold off ack indefinitely.
- **Load data hold.** o_loadData holds its value until the next load completes.

## Structure
- **Shared defines in types.vh:**
  - funct3 codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - LSU state encodings (LSU_IDLE, LSU_BUSY).
- **Sub-module `load_align`:** combinational select and extend from (rdata, addr[1:0], funct3) to a 32-bit result; reusable and unit-testable.
- **Store formatting** stays inline in the top-level module.

## Test plan
- **LW with zero-wait ack:**
  - addr=0x100, ack in first request cycle, rdata=0xDEADBEEF.
  - Expect o_dmemAddr=0x100 and be=1111.
  - Expect o_loadData=0xDEADBEEF with o_loadValid one cycle after ack.
  - Expect o_stall high exactly 1 cycle.
- **LB/LBU at addr=0x103 with ack after 3 wait cycles:**
  - rdata=0x80xxxxxx.
  - Expect LB → 0xFFFFFF80 and LBU → 0x00000080.
  - Expect o_stall high 4 cycles, with req, addr and be stable throughout.
- **SB and SH formatting:**
  - SB addr=0x202, rs2=0x12345678 → wdata=0x78787878, be=0100, we=1, addr=0x200.
  - SH addr=0x202 → wdata=0x56785678, be=1100.
- **Faults:**
  - LW addr=0x101, LH addr=0x3, funct3=011, SB with funct3=100.
  - Each → o_memFault=1, no o_dmemReq, o_stall=0.
- **Reset mid-access:**
  - Deassert i_rstn while BUSY and between clock edges.
  - Expect o_dmemReq=0 immediately and all outputs 0; a later ack is ignored and the state stays IDLE.
- **Back-to-back load then store with a spurious ack in IDLE:**
  - The spurious ack does nothing.
  - The second access issues its request exactly 1 cycle after the first ack.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types, widths and access-size codes for the memory-stage load/store unit.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } dmem_req_t;

  // Illegal size code for the direction, or address not aligned to the access size
  function automatic logic accessFault(input logic [2:0] funct3, input logic isWrite,
                                       input logic [1:0] addrLow);
    logic f;
    f = 1'b0;
    case (funct3)
      LSU_B:   f = 1'b0;
      LSU_H:   f = addrLow[0];
      LSU_W:   f = |addrLow;
      LSU_BU:  f = isWrite;
      LSU_HU:  f = isWrite | addrLow[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge port.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic            dmemReq;
  logic            dmemWe;
  logic [XLEN-1:0] dmemAddr;
  logic [XLEN-1:0] dmemWdata;
  logic [BE_W-1:0] dmemBe;
  logic            dmemAck;
  logic [XLEN-1:0] dmemRdata;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  dmemAck, dmemRdata
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output dmemAck, dmemRdata
  );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      byteOff,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result_c
);

  logic [7:0]  lane;
  logic [15:0] half;

  always_comb begin
    lane     = rdata[{byteOff, 3'b000} +: 8];
    half     = byteOff[1] ? rdata[31:16] : rdata[15:0];
    result_c = rdata;
    case (funct3)
      LSU_B:   result_c = {{24{lane[7]}}, lane};
      LSU_BU:  result_c = {24'h000000, lane};
      LSU_H:   result_c = {{16{half[15]}}, half};
      LSU_HU:  result_c = {16'h0000, half};
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request/ack transaction per load or store,
// with store lane formatting, load extension and pipeline stall.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_storeData,
  output logic              o_stall,
  output logic [XLEN-1:0]   o_loadData,
  output logic              o_loadValid,
  output logic              o_memFault,
  load_store_unit_if.master dmem
);

  localparam logic [BE_W-1:0] BE_LANE0 = BE_W'(1);
  localparam logic [BE_W-1:0] BE_ALL   = '1;

  lsu_state_e      state;
  dmem_req_t       reqQ;
  logic [1:0]      offQ;
  logic [2:0]      funct3Q;

  logic            access;
  logic            fault;
  logic            newOp;
  logic [XLEN-1:0] storeWdata;
  logic [BE_W-1:0] storeBe;
  logic [XLEN-1:0] alignedData;

  // Faults are only reported for an op that would otherwise start a transaction
  assign access     = i_valid & (i_memRead | i_memWrite);
  assign fault      = accessFault(i_funct3, i_memWrite, i_addr[1:0]);
  assign o_memFault = i_rstn & access & (state == LSU_IDLE) & fault;
  assign newOp      = i_rstn & access & (state == LSU_IDLE) & ~fault;

  always_comb begin
    o_stall = 1'b0;
    case (state)
      LSU_IDLE: o_stall = newOp;
      LSU_BUSY: o_stall = i_rstn & ~dmem.dmemAck;
      default:  o_stall = 1'b0;
    endcase
  end

  // Store lane replication and byte enables; loads always read the full word
  always_comb begin
    storeWdata = i_storeData;
    storeBe    = BE_ALL;
    if (i_memWrite) begin
      case (i_funct3)
        LSU_B: begin
          storeWdata = {4{i_storeData[7:0]}};
          storeBe    = BE_LANE0 << i_addr[1:0];
        end
        LSU_H: begin
          storeWdata = {2{i_storeData[15:0]}};
          storeBe    = i_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          storeWdata = i_storeData;
          storeBe    = BE_ALL;
        end
      endcase
    end
  end

  load_align u_loadAlign (
    .rdata    (dmem.dmemRdata),
    .byteOff  (offQ),
    .funct3   (funct3Q),
    .result_c (alignedData)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= LSU_IDLE;
      reqQ        <= '0;
      offQ        <= 2'b00;
      funct3Q     <= 3'b000;
      o_loadData  <= '0;
      o_loadValid <= 1'b0;
    end else begin
      o_loadValid <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (newOp) begin
            reqQ.we    <= i_memWrite;
            reqQ.addr  <= {i_addr[XLEN-1:2], 2'b00};
            reqQ.wdata <= storeWdata;
            reqQ.be    <= storeBe;
            offQ       <= i_addr[1:0];
            funct3Q    <= i_funct3;
            state      <= LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          if (dmem.dmemAck) begin
            state <= LSU_IDLE;
            if (!reqQ.we) begin
              o_loadData  <= alignedData;
              o_loadValid <= 1'b1;
            end
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  // Bus fields come straight from the latched request so they hold until ack
  assign dmem.dmemReq   = (state == LSU_BUSY);
  assign dmem.dmemWe    = reqQ.we;
  assign dmem.dmemAddr  = reqQ.addr;
  assign dmem.dmemWdata = reqQ.wdata;
  assign dmem.dmemBe    = reqQ.be;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written multi-cycle
// sequences and randomized ops against a behavioural access model.
module tb_load_store_unit;

  logic        clk;
  logic        rstn;
  logic        valid;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        stall;
  logic [31:0] loadData;
  logic        loadValid;
  logic        memFault;

  load_store_unit_if dmemIf ();

  load_store_unit dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_valid     (valid),
    .i_memRead   (memRead),
    .i_memWrite  (memWrite),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_storeData (storeData),
    .o_stall     (stall),
    .o_loadData  (loadData),
    .o_loadValid (loadValid),
    .o_memFault  (memFault),
    .dmem        (dmemIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] lastLoad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Access semantics from size/sign rules, using plain arithmetic
  task automatic refModel(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          output bit fault, output logic [31:0] wordAddr,
                          output logic [3:0] be, output logic [31:0] wdata,
                          output logic [31:0] loadVal);
    int     size;
    bit     sgn;
    bit     legal;
    int     off;
    longint v;
    size = 4; sgn = 1'b0; legal = 1'b1;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: legal = 1'b0;
    endcase
    if (wr && f3 >= 3'd4) legal = 1'b0;
    off      = int'(a % 4);
    fault    = !legal || ((a % size) != 0);
    wordAddr = a - 32'(off);
    be       = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
    if (size == 1)      wdata = 32'(sd[7:0]) * 32'h01010101;
    else if (size == 2) wdata = 32'(sd[15:0]) * 32'h00010001;
    else                wdata = sd;
    v = longint'(rd >> (8 * off)) & ((64'sd1 <<< (8 * size)) - 1);
    if (sgn && v >= (64'sd1 <<< (8 * size - 1))) v = v - (64'sd1 <<< (8 * size));
    loadVal = 32'(v);
  endtask

  task automatic idleInputs();
    valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    funct3 = 3'b000; addr = '0; storeData = '0;
    dmemIf.dmemAck = 1'b0; dmemIf.dmemRdata = '0;
  endtask

  // One op held in the stage until ack arrives after 'waits' request cycles
  task automatic doOp(input string nm, input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                      input int waits, input bit expFault, input logic [31:0] expAddr,
                      input logic [3:0] expBe, input logic [31:0] expWdata,
                      input logic [31:0] expLoad);
    int stallCnt;
    bit isLoad;
    isLoad = rd & ~wr;
    @(negedge clk);
    valid = 1'b1; memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd;
    dmemIf.dmemAck = 1'b0;
    #1;
    check({nm, ".fault"}, 32'(memFault), 32'(expFault));
    check({nm, ".reqIdle"}, 32'(dmemIf.dmemReq), 32'd0);
    check({nm, ".stallIssue"}, 32'(stall), 32'(!expFault));
    if (expFault) begin
      @(negedge clk);
      idleInputs();
      #1;
      check({nm, ".noReqAfterFault"}, 32'(dmemIf.dmemReq), 32'd0);
      check({nm, ".noLoadValid"}, 32'(loadValid), 32'd0);
      return;
    end
    stallCnt = 1;
    for (int c = 0; c <= waits; c++) begin
      @(negedge clk);
      dmemIf.dmemAck   = (c == waits);
      dmemIf.dmemRdata = (c == waits) ? rdat : $urandom();
      #1;
      check({nm, ".req"}, 32'(dmemIf.dmemReq), 32'd1);
      check({nm, ".addr"}, dmemIf.dmemAddr, expAddr);
      check({nm, ".be"}, 32'(dmemIf.dmemBe), 32'(expBe));
      check({nm, ".we"}, 32'(dmemIf.dmemWe), 32'(wr));
      if (wr) check({nm, ".wdata"}, dmemIf.dmemWdata, expWdata);
      check({nm, ".faultBusy"}, 32'(memFault), 32'd0);
      if (stall) stallCnt++;
    end
    check({nm, ".stallCycles"}, 32'(stallCnt), 32'(waits + 1));
    @(negedge clk);
    idleInputs();
    #1;
    check({nm, ".reqDone"}, 32'(dmemIf.dmemReq), 32'd0);
    check({nm, ".loadValid"}, 32'(loadValid), 32'(isLoad));
    if (isLoad) lastLoad = expLoad;
    check({nm, ".loadData"}, loadData, lastLoad);
  endtask

  typedef struct {
    string       nm;
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdat;
    int          waits;
    bit          fault;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit          mFault;
    logic [31:0] mAddr, mWdata, mLoad;
    logic [3:0]  mBe;

    vecs.push_back('{"lw0",    1, 0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{"lb103",  1, 0, 3'd0, 32'h103, 32'h0,        32'h80123456, 3, 0, 32'h100, 4'hF, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{"lbu103", 1, 0, 3'd4, 32'h103, 32'h0,        32'h80123456, 3, 0, 32'h100, 4'hF, 32'h0,        32'h00000080});
    vecs.push_back('{"sb202",  0, 1, 3'd0, 32'h202, 32'h12345678, 32'h0,        0, 0, 32'h200, 4'h4, 32'h78787878, 32'h0});
    vecs.push_back('{"sh202",  0, 1, 3'd1, 32'h202, 32'h12345678, 32'h0,        1, 0, 32'h200, 4'hC, 32'h56785678, 32'h0});
    vecs.push_back('{"lwMis",  1, 0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0});
    vecs.push_back('{"lhMis",  1, 0, 3'd1, 32'h3,   32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0});
    vecs.push_back('{"ld011",  1, 0, 3'd3, 32'h0,   32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0});
    vecs.push_back('{"sb100",  0, 1, 3'd4, 32'h0,   32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0});
    vecs.push_back('{"lh102",  1, 0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 1, 0, 32'h100, 4'hF, 32'h0,        32'hFFFF8001});
    vecs.push_back('{"lhu100", 1, 0, 3'd5, 32'h100, 32'h0,        32'h80017FFF, 2, 0, 32'h100, 4'hF, 32'h0,        32'h00007FFF});
    vecs.push_back('{"rwSw",   1, 1, 3'd2, 32'h10,  32'hCAFEF00D, 32'h0,        1, 0, 32'h10,  4'hF, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{"lb001",  1, 0, 3'd0, 32'h1,   32'h0,        32'h00007F00, 0, 0, 32'h0,   4'hF, 32'h0,        32'h0000007F});
    vecs.push_back('{"sh101",  0, 1, 3'd5, 32'h0,   32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0});
    vecs.push_back('{"lhuMis", 1, 0, 3'd5, 32'h201, 32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0});

    idleInputs();
    rstn = 1'b0;
    lastLoad = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.req", 32'(dmemIf.dmemReq), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.loadValid", 32'(loadValid), 32'd0);
    check("rst.loadData", loadData, 32'd0);
    check("rst.addr", dmemIf.dmemAddr, 32'd0);
    check("rst.be", 32'(dmemIf.dmemBe), 32'd0);
    rstn = 1'b1;

    foreach (vecs[i])
      doOp(vecs[i].nm, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].sd,
           vecs[i].rdat, vecs[i].waits, vecs[i].fault, vecs[i].expAddr, vecs[i].expBe,
           vecs[i].expWdata, vecs[i].expLoad);

    // Valid instruction that is neither load nor store
    @(negedge clk);
    valid = 1'b1; funct3 = 3'd2; addr = 32'h55;
    #1;
    check("nop.stall", 32'(stall), 32'd0);
    check("nop.fault", 32'(memFault), 32'd0);
    @(negedge clk);
    idleInputs();
    #1;
    check("nop.req", 32'(dmemIf.dmemReq), 32'd0);

    // Back-to-back load then store, spurious ack while idle
    @(negedge clk);
    valid = 1'b1; memRead = 1'b1; funct3 = 3'd2; addr = 32'h40;
    #1;
    check("b2b.stall0", 32'(stall), 32'd1);
    @(negedge clk);
    dmemIf.dmemAck = 1'b1; dmemIf.dmemRdata = 32'h11223344;
    #1;
    check("b2b.req1", 32'(dmemIf.dmemReq), 32'd1);
    check("b2b.stallAck", 32'(stall), 32'd0);
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b1; addr = 32'h44; storeData = 32'hA5A5A5A5;
    dmemIf.dmemAck = 1'b1; dmemIf.dmemRdata = 32'hFFFFFFFF;
    #1;
    check("b2b.loadValid", 32'(loadValid), 32'd1);
    check("b2b.loadData", loadData, 32'h11223344);
    check("b2b.reqGap", 32'(dmemIf.dmemReq), 32'd0);
    check("b2b.stallStore", 32'(stall), 32'd1);
    @(negedge clk);
    dmemIf.dmemAck = 1'b0;
    #1;
    check("b2b.req2", 32'(dmemIf.dmemReq), 32'd1);
    check("b2b.we2", 32'(dmemIf.dmemWe), 32'd1);
    check("b2b.addr2", dmemIf.dmemAddr, 32'h44);
    check("b2b.wdata2", dmemIf.dmemWdata, 32'hA5A5A5A5);
    check("b2b.noSpuriousLoad", 32'(loadValid), 32'd0);
    check("b2b.stallWait", 32'(stall), 32'd1);
    @(negedge clk);
    dmemIf.dmemAck = 1'b1;
    #1;
    check("b2b.stallAck2", 32'(stall), 32'd0);
    @(negedge clk);
    idleInputs();
    #1;
    check("b2b.reqEnd", 32'(dmemIf.dmemReq), 32'd0);
    check("b2b.storeNoLoad", 32'(loadValid), 32'd0);
    check("b2b.loadHold", loadData, 32'h11223344);
    lastLoad = 32'h11223344;

    // Asynchronous reset while a load is outstanding
    @(negedge clk);
    valid = 1'b1; memRead = 1'b1; funct3 = 3'd2; addr = 32'h80;
    @(negedge clk);
    #1;
    check("rstMid.reqBefore", 32'(dmemIf.dmemReq), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("rstMid.req", 32'(dmemIf.dmemReq), 32'd0);
    check("rstMid.stall", 32'(stall), 32'd0);
    check("rstMid.fault", 32'(memFault), 32'd0);
    check("rstMid.loadData", loadData, 32'd0);
    check("rstMid.addr", dmemIf.dmemAddr, 32'd0);
    check("rstMid.wdata", dmemIf.dmemWdata, 32'd0);
    check("rstMid.be", 32'(dmemIf.dmemBe), 32'd0);
    check("rstMid.we", 32'(dmemIf.dmemWe), 32'd0);
    lastLoad = '0;
    @(negedge clk);
    valid = 1'b0; memRead = 1'b0;
    dmemIf.dmemAck = 1'b1; dmemIf.dmemRdata = 32'h12345678;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rstMid.reqRel", 32'(dmemIf.dmemReq), 32'd0);
    @(negedge clk);
    dmemIf.dmemAck = 1'b0;
    #1;
    check("rstMid.lateAckReq", 32'(dmemIf.dmemReq), 32'd0);
    check("rstMid.lateAckValid", 32'(loadValid), 32'd0);
    check("rstMid.lateAckData", loadData, 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      bit          rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, sd, rdat;
      int          w;
      rd   = 1'($urandom_range(0, 1));
      wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom();
      sd   = $urandom();
      rdat = $urandom();
      w    = int'($urandom_range(0, 3));
      refModel(wr, f3, a, sd, rdat, mFault, mAddr, mBe, mWdata, mLoad);
      doOp($sformatf("rnd%0d", i), rd, wr, f3, a, sd, rdat, w, mFault, mAddr, mBe, mWdata, mLoad);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
